// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, region decode, and a
// clock-enabled output pipeline that keeps syncs, video, coordinates and strobes aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 11,
  parameter int PIPE_DLY = 0,
  parameter int FRAME_W  = 8
) (
  input  logic               refresh_clk,
  input  logic               rst,
  input  logic               ce,
  output logic               sync_h,
  output logic               sync_v,
  output logic               vidon,
  output logic [CW-1:0]      pixel_x,
  output logic [CW-1:0]      pixel_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               vid;
    logic [CW-1:0]      x;
    logic [CW-1:0]      y;
    logic               ls;
    logic               fs;
    logic [FRAME_W-1:0] fc;
  } stage_t;

  localparam stage_t STAGE_RST = '{hs: !H_POL, vs: !V_POL, vid: 1'b0, x: '0, y: '0,
                                   ls: 1'b0, fs: 1'b0, fc: '0};

  logic [CW-1:0]      hc_q, hc_d, vc_q, vc_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               h_last, v_last;

  always_comb begin
    h_last  = (hc_q == CW'(H_TOTAL - 1));
    v_last  = (vc_q == CW'(V_TOTAL - 1));
    hc_d    = hc_q;
    vc_d    = vc_q;
    frame_d = frame_q;
    if (ce) begin
      hc_d = h_last ? '0 : hc_q + CW'(1);
      if (h_last) begin
        vc_d = v_last ? '0 : vc_q + CW'(1);
        if (v_last) begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
    end
  end

  always_ff @(posedge refresh_clk or negedge rst) begin
    if (!rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      frame_q <= frame_d;
    end
  end

  // Region decode of the current counter value; becomes stage 0 of the pipeline.
  stage_t dec;
  logic   h_act, v_act;

  always_comb begin
    dec    = STAGE_RST;
    h_act  = (hc_q >= CW'(H_ACT_START)) && (hc_q < CW'(H_ACT_END));
    v_act  = (vc_q >= CW'(V_ACT_START)) && (vc_q < CW'(V_ACT_END));
    dec.hs = (hc_q < CW'(H_SYNC)) ? H_POL : !H_POL;
    dec.vs = (vc_q < CW'(V_SYNC)) ? V_POL : !V_POL;
    dec.vid = h_act && v_act;
    dec.x  = (h_act && v_act) ? hc_q - CW'(H_ACT_START) : '0;
    dec.y  = (h_act && v_act) ? vc_q - CW'(V_ACT_START) : '0;
    dec.ls = (hc_q == '0);
    dec.fs = (hc_q == '0) && (vc_q == '0);
    dec.fc = frame_q;
  end

  stage_t pipe_q [PIPE_DLY+1];
  stage_t pipe_d [PIPE_DLY+1];

  generate
    for (genvar gi = 0; gi <= PIPE_DLY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = ce ? dec : pipe_q[gi];
      end else begin : g_tail
        assign pipe_d[gi] = ce ? pipe_q[gi-1] : pipe_q[gi];
      end

      always_ff @(posedge refresh_clk or negedge rst) begin
        if (!rst) begin
          pipe_q[gi] <= STAGE_RST;
        end else begin
          pipe_q[gi] <= pipe_d[gi];
        end
      end
    end
  endgenerate

  assign sync_h      = pipe_q[PIPE_DLY].hs;
  assign sync_v      = pipe_q[PIPE_DLY].vs;
  assign vidon       = pipe_q[PIPE_DLY].vid;
  assign pixel_x     = pipe_q[PIPE_DLY].x;
  assign pixel_y     = pipe_q[PIPE_DLY].y;
  assign line_start  = pipe_q[PIPE_DLY].ls;
  assign frame_start = pipe_q[PIPE_DLY].fs;
  assign frame_cnt   = pipe_q[PIPE_DLY].fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 geometry plus a tiny 8x6 raster used
// for frame wrap, clock-enable stretching, pipeline delay and inverted polarity.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit small_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Default-geometry instance
  logic        rst_d;
  logic        sync_h_d, sync_v_d, vidon_d, line_start_d, frame_start_d;
  logic [10:0] pixel_x_d, pixel_y_d;
  logic [7:0]  frame_cnt_d;

  vga_timing_gen u_def (
    .refresh_clk(clk), .rst(rst_d), .ce(1'b1),
    .sync_h(sync_h_d), .sync_v(sync_v_d), .vidon(vidon_d),
    .pixel_x(pixel_x_d), .pixel_y(pixel_y_d),
    .line_start(line_start_d), .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
  );

  // Tiny raster: H = 2 sync + 1 bp + 4 active + 1 fp = 8, V = 1 + 1 + 3 + 1 = 6
  logic       rst_s, ce_c;
  logic       sync_h_s, sync_v_s, vidon_s, line_start_s, frame_start_s;
  logic [3:0] pixel_x_s, pixel_y_s;
  logic [1:0] frame_cnt_s;
  logic       sync_h_c, sync_v_c, vidon_c, line_start_c, frame_start_c;
  logic [3:0] pixel_x_c, pixel_y_c;
  logic [1:0] frame_cnt_c;
  logic       sync_h_p, sync_v_p, vidon_p, line_start_p, frame_start_p;
  logic [3:0] pixel_x_p, pixel_y_p;
  logic [1:0] frame_cnt_p;

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .CW(4), .FRAME_W(2)) u_small (
    .refresh_clk(clk), .rst(rst_s), .ce(1'b1),
    .sync_h(sync_h_s), .sync_v(sync_v_s), .vidon(vidon_s),
    .pixel_x(pixel_x_s), .pixel_y(pixel_y_s),
    .line_start(line_start_s), .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .CW(4), .FRAME_W(2)) u_ce (
    .refresh_clk(clk), .rst(rst_s), .ce(ce_c),
    .sync_h(sync_h_c), .sync_v(sync_v_c), .vidon(vidon_c),
    .pixel_x(pixel_x_c), .pixel_y(pixel_y_c),
    .line_start(line_start_c), .frame_start(frame_start_c), .frame_cnt(frame_cnt_c)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(3),
                   .CW(4), .FRAME_W(2)) u_pipe (
    .refresh_clk(clk), .rst(rst_s), .ce(1'b1),
    .sync_h(sync_h_p), .sync_v(sync_v_p), .vidon(vidon_p),
    .pixel_x(pixel_x_p), .pixel_y(pixel_y_p),
    .line_start(line_start_p), .frame_start(frame_start_p), .frame_cnt(frame_cnt_p)
  );

  // Expected packed outputs {hs,vs,vid,ls,fs,fc[1:0],x[3:0],y[3:0]} of the tiny raster
  // after n enable edges past reset release, for output delay d and sync polarity pol.
  function automatic logic [31:0] exp_small(input int n, input int d, input bit pol);
    int k, hc, vc, fc;
    logic hs, vs, vid, ls, fs;
    logic [3:0] x, y;
    hs = !pol; vs = !pol; vid = 1'b0; ls = 1'b0; fs = 1'b0; fc = 0; x = '0; y = '0;
    if (n - d >= 1) begin
      k   = n - 1 - d;
      hc  = k % 8;
      vc  = (k / 8) % 6;
      fc  = (k / 48) % 4;
      hs  = (hc < 2) ? pol : !pol;
      vs  = (vc < 1) ? pol : !pol;
      vid = (hc >= 3) && (hc < 7) && (vc >= 2) && (vc < 5);
      x   = vid ? 4'(hc - 3) : 4'd0;
      y   = vid ? 4'(vc - 2) : 4'd0;
      ls  = (hc == 0);
      fs  = (hc == 0) && (vc == 0);
    end
    return 32'({hs, vs, vid, ls, fs, 2'(fc), x, y});
  endfunction

  task automatic run_default(input int last);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      check("def_hsync", 32'(sync_h_d), (((n - 1) % 800) < 96) ? 32'd0 : 32'd1);
      check("def_line_start", 32'(line_start_d), (((n - 1) % 800) == 0) ? 32'd1 : 32'd0);
      case (n)
        1:     check("def_frame_start_1", 32'(frame_start_d), 32'd1);
        801:   check("def_frame_start_801", 32'(frame_start_d), 32'd0);
        1600:  check("def_vsync_1600", 32'(sync_v_d), 32'd0);
        1601:  check("def_vsync_1601", 32'(sync_v_d), 32'd1);
        24944: check("def_vidon_24944", 32'(vidon_d), 32'd0);
        24945: begin
          check("def_vidon_24945", 32'(vidon_d), 32'd1);
          check("def_x_24945", 32'(pixel_x_d), 32'd0);
          check("def_y_24945", 32'(pixel_y_d), 32'd0);
        end
        25000: begin
          check("def_vidon_25000", 32'(vidon_d), 32'd1);
          check("def_x_25000", 32'(pixel_x_d), 32'd55);
        end
        25584: begin
          check("def_vidon_25584", 32'(vidon_d), 32'd1);
          check("def_x_25584", 32'(pixel_x_d), 32'd639);
        end
        25585: begin
          check("def_vidon_25585", 32'(vidon_d), 32'd0);
          check("def_x_25585", 32'(pixel_x_d), 32'd0);
        end
        25745: begin
          check("def_vidon_25745", 32'(vidon_d), 32'd1);
          check("def_x_25745", 32'(pixel_x_d), 32'd0);
          check("def_y_25745", 32'(pixel_y_d), 32'd1);
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_def_reset(input string tag);
    check({tag, "_hsync"}, 32'(sync_h_d), 32'd1);
    check({tag, "_vsync"}, 32'(sync_v_d), 32'd1);
    check({tag, "_vidon"}, 32'(vidon_d), 32'd0);
    check({tag, "_x"}, 32'(pixel_x_d), 32'd0);
    check({tag, "_y"}, 32'(pixel_y_d), 32'd0);
    check({tag, "_strobes"}, 32'({line_start_d, frame_start_d}), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt_d), 32'd0);
  endtask

  initial begin
    rst_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_def_reset("def_reset");
    @(negedge clk) rst_d = 1'b1;
    run_default(25000);
    // Mid-frame reset lands between edges, inside the active region.
    @(negedge clk) rst_d = 1'b0;
    #1;
    check_def_reset("def_midreset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_d = 1'b1;
    #1;
    check("def_hsync_pre_edge1", 32'(sync_h_d), 32'd1);
    run_default(25800);
    wait (small_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_s = 1'b0;
    ce_c  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("small_reset", 32'({sync_h_s, sync_v_s, vidon_s, line_start_s, frame_start_s,
                              frame_cnt_s, pixel_x_s, pixel_y_s}), exp_small(0, 0, 1'b0));
    check("pipe_reset_sync", 32'({sync_h_p, sync_v_p}), 32'd0);
    @(negedge clk) rst_s = 1'b1;
    for (int m = 1; m <= 800; m++) begin
      ce_c = (m % 4 == 0);
      @(posedge clk); #1;
      check("small_raster", 32'({sync_h_s, sync_v_s, vidon_s, line_start_s, frame_start_s,
                                 frame_cnt_s, pixel_x_s, pixel_y_s}), exp_small(m, 0, 1'b0));
      check("ce_raster", 32'({sync_h_c, sync_v_c, vidon_c, line_start_c, frame_start_c,
                              frame_cnt_c, pixel_x_c, pixel_y_c}), exp_small(m / 4, 0, 1'b0));
      check("pipe_raster", 32'({sync_h_p, sync_v_p, vidon_p, line_start_p, frame_start_p,
                                frame_cnt_p, pixel_x_p, pixel_y_p}), exp_small(m, 3, 1'b1));
      case (m)
        48:  check("small_fcnt_48", 32'(frame_cnt_s), 32'd0);
        49: begin
          check("small_fcnt_49", 32'(frame_cnt_s), 32'd1);
          check("small_fstart_49", 32'(frame_start_s), 32'd1);
        end
        52:  check("pipe_fcnt_52", 32'(frame_cnt_p), 32'd1);
        145: check("small_fcnt_145", 32'(frame_cnt_s), 32'd3);
        193: check("small_fcnt_wrap_193", 32'(frame_cnt_s), 32'd0);
        196: check("ce_fcnt_196", 32'(frame_cnt_c), 32'd1);
        default: ;
      endcase
    end
    small_done = 1'b1;
  end

endmodule
